// File: rtl/synth_arith_pkg.sv
// Shared arithmetic definitions: divider FSM states, default operand width and counter sizing.
package synth_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed for a counter that must hold the value w itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step_cell.sv
// One restoring-division step: shift in the next dividend bit, trial subtract, restore on borrow.
module div_step_cell #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   p_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = (p_in << 1) | {{WIDTH{1'b0}}, dvd_bit};
        trial   = shifted - {1'b0, divisor};
        // MSB of the WIDTH+1 bit difference is the borrow.
        q_bit   = ~trial[WIDTH];
        p_out   = q_bit ? trial : shifted;
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// RUN   | one shift/subtract step per cycle, WIDTH cycles
// DONE  | single-cycle done pulse; start here chains the next division
module seq_divider
    import synth_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] q_sh;

    logic [WIDTH:0]   p_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] zero_q;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;
`endif

    div_step_cell #(.WIDTH(WIDTH)) u_step (
        .p_in    (p_reg),
        .dvd_bit (dvd_sh[WIDTH-1]),
        .divisor (dvs),
        .p_out   (p_next),
        .q_bit   (q_bit)
    );

    always_comb begin
        q_next = (q_sh << 1) | {{(WIDTH-1){1'b0}}, q_bit};
`ifdef SEQ_DIVIDER_SIGNED_EN
        dvd_mag = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
        dvs_mag = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;
        zero_q  = dividend[WIDTH-1] ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
        q_final = neg_q ? ('0 - q_next) : q_next;
        r_final = neg_r ? ('0 - p_next[WIDTH-1:0]) : p_next[WIDTH-1:0];
`else
        dvd_mag = dividend;
        dvs_mag = divisor;
        zero_q  = '1;
        q_final = q_next;
        r_final = p_next[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            cnt         <= '0;
            p_reg       <= '0;
            dvd_sh      <= '0;
            dvs         <= '0;
            q_sh        <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    busy <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= zero_q;
                            remainder   <= dividend;
                        end else begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            cnt    <= CW'(WIDTH);
                            p_reg  <= '0;
                            q_sh   <= '0;
                            dvd_sh <= dvd_mag;
                            dvs    <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            neg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_r  <= dividend[WIDTH-1];
`endif
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    p_reg  <= p_next;
                    dvd_sh <= dvd_sh << 1;
                    q_sh   <= q_next;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= 1'b0;
                        quotient    <= q_final;
                        remainder   <= r_final;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8) with hand-computed expected results.
module tb_seq_divider;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Returns the cycle index (1 = cycle after the accepting edge) at which done is seen.
    task automatic wait_done(input string tag, input int n_in, output int n);
        n = n_in;
        while (done !== 1'b1 && n < 30) begin
            chk({tag, "_busy"}, busy, 1);
            tick();
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int n, input int exp_lat,
                                input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_in_done"}, busy, 0);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, ez);
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_lat, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez);
        int n;
        start_op(a, b);
        wait_done(tag, 1, n);
        check_result(tag, n, exp_lat, eq, er, ez);
        tick();
        chk({tag, "_done_single"}, done, 0);
    endtask

    initial begin
        int n;
        logic seen_done;

        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_div("s_m7_2", 8'hF9, 8'h02, 9, 8'hFD, 8'hFF, 1'b0);
        run_div("s_7_m2", 8'h07, 8'hFE, 9, 8'hFD, 8'h01, 1'b0);
        run_div("s_m128_m1", 8'h80, 8'hFF, 9, 8'h80, 8'h00, 1'b0);
        run_div("s_m5_0", 8'hFB, 8'h00, 1, 8'h01, 8'hFB, 1'b1);
        run_div("s_5_0", 8'd5, 8'h00, 1, 8'hFF, 8'd5, 1'b1);
`else
        run_div("u_200_7", 8'd200, 8'd7, 9, 8'd28, 8'd4, 1'b0);
        run_div("u_5_0", 8'd5, 8'd0, 1, 8'hFF, 8'd5, 1'b1);
        run_div("u_255_255", 8'd255, 8'd255, 9, 8'd1, 8'd0, 1'b0);
        run_div("u_3_10", 8'd3, 8'd10, 9, 8'd0, 8'd3, 1'b0);
        run_div("u_255_1", 8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
        run_div("u_0_9", 8'd0, 8'd9, 9, 8'd0, 8'd0, 1'b0);

        // start during RUN is ignored, then start in DONE chains the next division
        start_op(8'd200, 8'd7);
        tick();
        tick();
        dividend = 8'd100;
        divisor  = 8'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done("ign", 4, n);
        check_result("ign", n, 9, 8'd28, 8'd4, 1'b0);
        start_op(8'd100, 8'd3);
        wait_done("b2b", 1, n);
        check_result("b2b", n, 9, 8'd33, 8'd1, 1'b0);
        tick();
        chk("b2b_done_single", done, 0);
        chk("b2b_quotient_held", quotient, 8'd33);
        chk("b2b_remainder_held", remainder, 8'd1);

        // reset in the middle of a RUN aborts without a done pulse
        start_op(8'd200, 8'd7);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0) seen_done = 1'b1;
            tick();
        end
        chk("abort_no_done", seen_done, 0);
        run_div("post_abort_100_3", 8'd100, 8'd3, 9, 8'd33, 8'd1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
